// File: rtl/latch_snapshot_streamer_if.sv
// Byte stream from the snapshot streamer to the UART transmitter (valid/ready).
interface latch_snapshot_streamer_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    // Streamer side drives the byte, the TX side answers with ready
    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/latch_snapshot_streamer.sv
// Debug-frame generator: captures NUM_WORDS pipeline-latch words on a trigger and
// streams them as SYNC, COUNT, payload bytes and an optional XOR checksum.
module latch_snapshot_streamer #(
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned WORD_W      = 32,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_WORDS*WORD_W-1:0]   in_snapshot,
    input  logic                          in_trigger,
    input  logic                          in_abort,
    input  logic                          in_clr_ovr,
    latch_snapshot_streamer_if.master     tx,
    output logic                          out_busy,
    output logic                          out_done,
    output logic                          out_overrun
);

    localparam int unsigned BPW        = (WORD_W + 7) / 8;
    localparam int unsigned PAD_W      = BPW * 8;
    localparam int unsigned SNAP_W     = NUM_WORDS * WORD_W;
    localparam int unsigned BYTE_CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned WORD_CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BPW - 1);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_COUNT,
        ST_PAYLOAD,
        ST_CHECK
    } state_e;

    state_e                  state_q, state_d;
    logic [SNAP_W-1:0]       snap_q, snap_d;
    logic [BYTE_CNT_W-1:0]   byte_q, byte_d;
    logic [WORD_CNT_W-1:0]   word_q, word_d;
    logic [7:0]              csum_q, csum_d;
    logic [7:0]              data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ovr_q, ovr_d;
    logic                    hs;

    // Byte idx of captured word, zero-padded to whole bytes and ordered per MSB_FIRST
    function automatic logic [7:0] payload_byte(
        input logic [SNAP_W-1:0]     snap,
        input logic [WORD_CNT_W-1:0] word,
        input logic [BYTE_CNT_W-1:0] idx
    );
        logic [PAD_W-1:0]      w;
        logic [BYTE_CNT_W-1:0] sel;
        w   = PAD_W'(snap[word*WORD_W +: WORD_W]);
        sel = MSB_FIRST ? (LAST_BYTE - idx) : idx;
        return w[sel*8 +: 8];
    endfunction

    // A byte counts as transferred only when presented, accepted and not aborted
    assign hs = busy_q & tx.ready & ~in_abort;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic; out_data is computed for the state being entered so it is registered
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        byte_d  = byte_q;
        word_d  = word_q;
        csum_d  = csum_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        // Trigger during a frame is dropped but remembered; set beats clear
        if (in_trigger && busy_q) begin
            ovr_d = 1'b1;
        end else if (in_clr_ovr) begin
            ovr_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (in_trigger) begin
                    snap_d  = in_snapshot;
                    csum_d  = '0;
                    byte_d  = '0;
                    word_d  = '0;
                    data_d  = SYNC_BYTE;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (hs) begin
                    data_d  = 8'(NUM_WORDS);
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (hs) begin
                    csum_d  = csum_q ^ data_q;
                    data_d  = payload_byte(snap_q, '0, '0);
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (hs) begin
                    csum_d = csum_q ^ data_q;
                    if (byte_q == LAST_BYTE) begin
                        byte_d = '0;
                        if (word_q == LAST_WORD) begin
                            if (CHECKSUM_EN) begin
                                data_d  = csum_q ^ data_q;
                                state_d = ST_CHECK;
                            end else begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            word_d = WORD_CNT_W'(word_q + 1'b1);
                            data_d = payload_byte(snap_q, WORD_CNT_W'(word_q + 1'b1), '0);
                        end
                    end else begin
                        byte_d = BYTE_CNT_W'(byte_q + 1'b1);
                        data_d = payload_byte(snap_q, word_q, BYTE_CNT_W'(byte_q + 1'b1));
                    end
                end
            end
            ST_CHECK: begin
                if (hs) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort drops the frame at this edge; hs is already suppressed so nothing counts
        if (in_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign tx.data     = data_q;
    assign tx.valid    = busy_q;
    assign out_busy    = busy_q;
    assign out_done    = done_q;
    assign out_overrun = ovr_q;

endmodule

// File: tb/tb_latch_snapshot_streamer.sv
// Bench: two streamer configurations (MSB-first with checksum, LSB-first without)
// driven by shared stimulus and checked against a queue-based frame model.
module tb_latch_snapshot_streamer;

    typedef logic [7:0] bq_t [$];

    localparam int unsigned NW  = 2;
    localparam int unsigned WW  = 12;
    localparam int unsigned BPW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [23:0]   snap;
    logic          trig, abort, clr, ready;
    logic          busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int dcnt_a    = 0;

    latch_snapshot_streamer_if ifa ();
    latch_snapshot_streamer_if ifb ();
    assign ifa.ready = ready;
    assign ifb.ready = ready;

    latch_snapshot_streamer #(
        .NUM_WORDS(NW), .WORD_W(WW), .MSB_FIRST(1'b1), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .in_snapshot(snap), .in_trigger(trig), .in_abort(abort),
        .in_clr_ovr(clr), .tx(ifa), .out_busy(busy_a), .out_done(done_a), .out_overrun(ovr_a)
    );

    latch_snapshot_streamer #(
        .NUM_WORDS(NW), .WORD_W(WW), .MSB_FIRST(1'b0), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .in_snapshot(snap), .in_trigger(trig), .in_abort(abort),
        .in_clr_ovr(clr), .tx(ifb), .out_busy(busy_b), .out_done(done_b), .out_overrun(ovr_b)
    );

    always #5 clk = ~clk;

    logic [7:0] dat [2];
    logic       vld [2];
    logic       bsy [2];
    logic       dne [2];
    logic       ovr [2];
    assign dat[0] = ifa.data;  assign dat[1] = ifb.data;
    assign vld[0] = ifa.valid; assign vld[1] = ifb.valid;
    assign bsy[0] = busy_a;    assign bsy[1] = busy_b;
    assign dne[0] = done_a;    assign dne[1] = done_b;
    assign ovr[0] = ovr_a;     assign ovr[1] = ovr_b;

    bq_t EXP_A = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h96};
    bq_t EXP_B = '{8'hA5, 8'h02, 8'h23, 8'h01, 8'hBC, 8'h0A};
    bq_t EXP_A_ABORT = '{8'hA5, 8'h02, 8'h01, 8'h23};
    bq_t EXP_B_ABORT = '{8'hA5, 8'h02, 8'h23, 8'h01};

    bq_t rx_a, rx_b;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_q(input string nm, input bq_t got, input bq_t exp);
        check({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size()) check($sformatf("%s_byte%0d", nm, i), got[i], exp[i]);
    endtask

    // Whole frame from the rules: sync, count, words in order, optional XOR of all but sync
    function automatic bq_t build(input bit msb, input bit cs, input logic [23:0] s);
        bq_t        q;
        logic [7:0] x, b;
        logic [15:0] w;
        q.push_back(8'hA5);
        q.push_back(8'(NW));
        x = 8'(NW);
        for (int k = 0; k < NW; k++) begin
            w = 16'(s[k*WW +: WW]);
            for (int i = 0; i < BPW; i++) begin
                b = 8'(w >> (8 * (msb ? (BPW - 1 - i) : i)));
                q.push_back(b);
                x = x ^ b;
            end
        end
        if (cs) q.push_back(x);
        return q;
    endfunction

    // Model: remaining bytes of the frame in flight plus busy/done/overrun flags
    bq_t mq [2];
    bit  mb [2];
    bit  md [2];
    bit  mo [2];

    initial begin
        for (int d = 0; d < 2; d++) begin mb[d] = 0; md[d] = 0; mo[d] = 0; end
        forever begin
            @(posedge clk or negedge reset);
            for (int d = 0; d < 2; d++) begin
                if (!reset) begin
                    mq[d].delete(); mb[d] = 0; md[d] = 0; mo[d] = 0;
                end else begin
                    bit was;
                    was   = mb[d];
                    md[d] = 0;
                    if (trig && was) mo[d] = 1;
                    else if (clr) mo[d] = 0;
                    if (!was) begin
                        if (trig) begin
                            mq[d] = build(d == 0, d == 0, snap);
                            mb[d] = 1;
                        end
                    end else if (abort) begin
                        mq[d].delete();
                        mb[d] = 0;
                    end else if (ready) begin
                        void'(mq[d].pop_front());
                        if (mq[d].size() == 0) begin mb[d] = 0; md[d] = 1; end
                    end
                end
            end
        end
    end

    // Record transferred bytes of each stream
    initial forever begin
        @(posedge clk);
        if (reset && ready && !abort) begin
            if (ifa.valid) rx_a.push_back(ifa.data);
            if (ifb.valid) rx_b.push_back(ifb.data);
        end
    end

    // Per-cycle compare against the model, plus hold-during-stall check
    initial begin
        logic       pv [2];
        logic [7:0] pd [2];
        logic       pr, pa;
        pv[0] = 0; pv[1] = 0; pr = 0; pa = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                pv[0] = 0; pv[1] = 0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("valid%0d", d), vld[d], mb[d]);
                    check($sformatf("busy%0d", d), bsy[d], mb[d]);
                    check($sformatf("done%0d", d), dne[d], md[d]);
                    check($sformatf("ovr%0d", d), ovr[d], mo[d]);
                    if (mb[d] && mq[d].size() > 0) check($sformatf("data%0d", d), dat[d], mq[d][0]);
                    if (pv[d] && !pr && !pa && vld[d]) check($sformatf("stall_hold%0d", d), dat[d], pd[d]);
                    pv[d] = vld[d];
                    pd[d] = dat[d];
                end
                if (done_a) dcnt_a++;
                pr = ready;
                pa = abort;
            end
        end
    end

    task automatic pulse_trig();
        @(negedge clk); trig = 1;
        @(negedge clk); trig = 0;
    endtask

    // Bounded wait for done on stream A; cycle 1 is the cycle after the trigger cycle
    task automatic wait_done(input int budget, input bit bp, output int la, output int lb);
        la = -1; lb = -1;
        for (int c = 1; c <= budget; c++) begin
            if (bp) begin
                ready = ((c % 9) >= 3 && (c % 9) <= 7) ? 1'b0 : 1'($urandom_range(0, 1));
                snap  = 24'($urandom);
            end
            #1;
            if (done_b && lb < 0) lb = c;
            if (done_a) begin la = c; break; end
            @(negedge clk);
        end
        if (la < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int la, lb, dsave;
        reset = 0; trig = 0; abort = 0; clr = 0; ready = 0; snap = '0;
        #1;
        check("rst_data", ifa.data, 8'h00);
        check("rst_valid", ifa.valid, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ovr", ovr_a, 0);
        repeat (2) @(negedge clk);
        reset = 1;

        // Straight frame, ready held high
        ready = 1; snap = 24'hABC123;
        rx_a.delete(); rx_b.delete();
        dsave = dcnt_a;
        pulse_trig();
        wait_done(40, 0, la, lb);
        check("lat_a", la, 8);
        check("lat_b", lb, 7);
        check_q("frame_a", rx_a, EXP_A);
        check_q("frame_b", rx_b, EXP_B);
        @(negedge clk);
        check("done_once", dcnt_a - dsave, 1);

        // Backpressure with stalls while the snapshot input keeps changing
        rx_a.delete(); rx_b.delete();
        snap = 24'hABC123;
        pulse_trig();
        wait_done(300, 1, la, lb);
        check_q("bp_a", rx_a, EXP_A);
        check_q("bp_b", rx_b, EXP_B);
        ready = 1; snap = 24'hABC123;

        // Overrun during payload, clear, then trigger in the done cycle
        rx_a.delete(); rx_b.delete();
        pulse_trig();
        repeat (2) @(negedge clk);
        trig = 1;
        @(negedge clk); trig = 0;
        #1;
        check("ovr_set_a", ovr_a, 1);
        check("ovr_set_b", ovr_b, 1);
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        #1;
        check("ovr_clr_a", ovr_a, 0);
        @(negedge clk);
        wait_done(40, 0, la, lb);
        check_q("ovr_frame_a", rx_a, EXP_A);
        check_q("ovr_frame_b", rx_b, EXP_B);
        rx_a.delete(); rx_b.delete();
        trig = 1;
        @(negedge clk); trig = 0;
        #1;
        check("retrig_busy", busy_a, 1);
        check("retrig_data", ifa.data, 8'hA5);
        check("retrig_ovr_a", ovr_a, 0);
        check("retrig_ovr_b", ovr_b, 0);
        @(negedge clk);
        wait_done(40, 0, la, lb);
        check_q("retrig_frame_a", rx_a, EXP_A);

        // Abort on the third payload byte
        rx_a.delete(); rx_b.delete();
        pulse_trig();
        repeat (4) @(negedge clk);
        abort = 1;
        @(negedge clk); abort = 0;
        #1;
        check("abort_valid", ifa.valid, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_valid_b", ifb.valid, 0);
        dsave = dcnt_a;
        check_q("abort_a", rx_a, EXP_A_ABORT);
        check_q("abort_b", rx_b, EXP_B_ABORT);
        repeat (3) @(negedge clk);
        check("abort_no_done", dcnt_a - dsave, 0);
        rx_a.delete(); rx_b.delete();
        pulse_trig();
        wait_done(40, 0, la, lb);
        check_q("post_abort_a", rx_a, EXP_A);

        // Asynchronous reset while in COUNT
        rx_a.delete(); rx_b.delete();
        pulse_trig();
        @(posedge clk);
        #2 reset = 0;
        #1;
        check("mrst_data", ifa.data, 8'h00);
        check("mrst_valid", ifa.valid, 0);
        check("mrst_busy", busy_a, 0);
        check("mrst_done", done_a, 0);
        check("mrst_ovr", ovr_a, 0);
        check("mrst_data_b", ifb.data, 8'h00);
        @(negedge clk);
        @(negedge clk); reset = 1;
        rx_a.delete(); rx_b.delete();
        pulse_trig();
        wait_done(40, 0, la, lb);
        check("post_rst_lat", la, 8);
        check_q("post_rst_a", rx_a, EXP_A);
        check_q("post_rst_b", rx_b, EXP_B);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/latch_snapshot_streamer.md
# latch_snapshot_streamer

Parametrised debug-frame generator for the pipeline debug path. On a trigger it captures a flat vector of NUM_WORDS pipeline-latch words in one cycle, then streams them as a framed byte sequence (sync, count, payload, optional XOR checksum) over a valid/ready byte interface feeding the UART transmitter. It sits between the pipeline latch taps and the debug unit's TX path. It generalises single-word latch muxing to configurable word count, word width, byte order and integrity check, and adds overrun detection and abort.

## Interface
- NUM_WORDS, 16, number of captured words; range 1..255.
- WORD_W, 32, width of each word in bits; range 1..64. BPW = ceil(WORD_W/8) bytes per word.
- MSB_FIRST, 1, 1: most significant byte of each word is sent first; 0: least significant byte first.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- CHECKSUM_EN, 1, 1: append the checksum byte; 0: omit it.
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_snapshot  in  NUM_WORDS*WORD_W  word k occupies bits [k*WORD_W +: WORD_W].
- in_trigger  in  1  start-capture request, sampled each cycle.
- in_abort  in  1  terminates the current frame.
- in_clr_ovr  in  1  clears out_overrun.
- in_ready  in  1  downstream (UART TX) accepts the byte.
- out_data  out  8  current byte.
- out_valid  out  1  out_data is valid.
- out_busy  out  1  a frame is in progress.
- out_done  out  1  one-cycle pulse: the frame completed normally.
- out_overrun  out  1  sticky flag: a trigger arrived while busy.

## Operation
- States: IDLE, SYNC, COUNT, PAYLOAD, CHECK.
- IDLE:
  - On in_trigger, latch in_snapshot into the internal snapshot register, clear the checksum accumulator and the byte/word counters, and go to SYNC.
- SYNC: out_data = SYNC_BYTE. On handshake, go to COUNT.
- COUNT: out_data = NUM_WORDS[7:0]. On handshake, go to PAYLOAD.
- PAYLOAD:
  - Words are sent in index order 0..NUM_WORDS-1, BPW bytes each.
  - Unused high bits of the last byte are zero-padded.
  - The byte counter wraps 0..BPW-1; the word counter increments on wrap.
  - After the last byte of word NUM_WORDS-1, go to CHECK if CHECKSUM_EN, else go to IDLE.
- CHECK: out_data = XOR of the COUNT byte and all payload bytes (the sync byte is excluded). On handshake, go to IDLE.
- Handshake: a byte transfers at the rising edge where out_valid=1 and in_ready=1.
  - While out_valid=1 and in_ready=0, out_data is held stable.
  - The checksum accumulates only on handshakes.
- The captured snapshot is frozen for the whole frame. Changes on in_snapshot after capture have no effect.
- in_trigger while out_busy=1 is ignored and sets out_overrun. The frame continues.
- out_overrun clears on in_clr_ovr. If in_clr_ovr and a new overrun occur in the same cycle, set wins.
- in_abort in any non-IDLE state:
  - Returns to IDLE at the next edge, with out_valid=0 and no out_done.
  - The byte on out_data at that edge is not counted as transferred, even if in_ready=1.
  - in_abort has priority over in_trigger in the same cycle.
- out_done:
  - Asserts in the cycle after the final handshake; the state is IDLE in that cycle.
  - A trigger in that same cycle is accepted normally and does not set overrun.

## Timing
- Reset values: state IDLE, out_data 8'h00, out_valid 0, out_busy 0, out_done 0, out_overrun 0. Counters, snapshot and checksum are 0.
- Reset asserted mid-frame clears everything immediately (asynchronously). No partial frame resumes after reset.
- out_valid and out_busy are registered:
  - Trigger sampled at edge t gives out_valid=1 with SYNC_BYTE from t onward.
  - out_busy=1 from t until the edge of the final handshake or abort.
- Zero-bubble streaming: with in_ready held 1, one byte transfers per cycle.
- Frame length: L = 2 + NUM_WORDS*BPW + CHECKSUM_EN bytes.
- Trigger-to-done latency with in_ready=1: L+1 cycles.
- out_valid stays 1 from SYNC through the last byte. It never drops between bytes.

## Test plan
- Checksum, MSB-first byte order:
  - Stimulus: NUM_WORDS=2, WORD_W=12, MSB_FIRST=1, CHECKSUM_EN=1, words {0x123, 0xABC}, pulse trigger, in_ready=1.
  - Required: bytes A5 02 01 23 0A BC 96.
  - Required: out_done pulses once, 8 cycles after trigger.
- LSB-first order, no checksum:
  - Stimulus: same words, MSB_FIRST=0, CHECKSUM_EN=0.
  - Required: bytes A5 02 23 01 BC 0A, 6 bytes total, no checksum byte.
- Backpressure and snapshot freeze:
  - Stimulus: toggle in_ready randomly (including 5-cycle stalls). Change in_snapshot every cycle after trigger.
  - Required: identical byte sequence to the first scenario. out_data stable during every stall.
- Overrun:
  - Stimulus: trigger during PAYLOAD.
  - Required: out_overrun=1 the next cycle. The frame bytes are unchanged.
  - Stimulus: in_clr_ovr.
  - Required: out_overrun returns to 0.
  - Stimulus: trigger in the out_done cycle.
  - Required: a new frame starts and out_overrun stays 0.
- Abort:
  - Stimulus: in_abort on the 3rd payload byte with in_ready=1.
  - Required: out_valid=0 and out_busy=0 next cycle, no out_done.
  - Stimulus: next trigger.
  - Required: a full frame from A5.
- Reset mid-frame:
  - Stimulus: assert reset (low) asynchronously between edges while in COUNT.
  - Required: all outputs at their reset values immediately.
  - Stimulus: release reset, then trigger.
  - Required: a correct full frame.
